// File: rtl/score_engine.sv
// Pacman score unit: event FIFO with a registered read stage, ghost-chain points, saturating score, high score.
// Optional SCORE_EXTRA_LIFE_EN macro builds the extra-life threshold detector; otherwise extra_life is tied low.
module score_engine #(
   parameter int SCORE_W         = 24,
   parameter int EVT_DEPTH       = 4,
   parameter int PELLET_PTS      = 10,
   parameter int POWER_PTS       = 50,
   parameter int FRUIT_PTS       = 100,
   parameter int GHOST_BASE      = 200,
   parameter int GHOST_CHAIN_MAX = 4,
   parameter int LIFE_THRESH     = 10000
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               new_game,
   input  logic               evt_valid,
   input  logic [1:0]         evt_type,
   output logic               evt_ready,
   input  logic               chain_clear,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] high_score,
   output logic               extra_life,
   output logic               fifo_empty
);

   localparam int PTR_W = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
   localparam int IDX_W = (GHOST_CHAIN_MAX > 1) ? $clog2(GHOST_CHAIN_MAX) : 1;
   // Points can exceed a narrow score width, so the adder is kept at least 33 bits wide.
   localparam int SUM_W = (SCORE_W + 1 > 33) ? SCORE_W + 1 : 33;
   localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(GHOST_CHAIN_MAX - 1);
   localparam logic [SUM_W-1:0] SCORE_MAX = {{(SUM_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};
   localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(EVT_DEPTH);

   typedef enum logic [1:0] {
      EVT_PELLET = 2'b00,
      EVT_POWER  = 2'b01,
      EVT_FRUIT  = 2'b10,
      EVT_GHOST  = 2'b11
   } evt_t;

   logic [1:0]         mem [EVT_DEPTH];
   logic [PTR_W:0]     wr_ptr_reg, rd_ptr_reg;
   logic [PTR_W:0]     count;
   logic               raw_empty, full;
   logic               push, load, pop, score_evt;
   logic               rd_valid_reg;
   evt_t               rd_type_reg;
   logic [IDX_W-1:0]   idx_reg, idx_next;
   logic [SCORE_W-1:0] score_reg, score_next;
   logic [SCORE_W-1:0] high_reg;
   logic [SUM_W-1:0]   pts, sum;

   assign count      = wr_ptr_reg - rd_ptr_reg;
   assign raw_empty  = (count == '0);
   assign full       = (count == DEPTH_CNT);
   assign evt_ready  = !full && !new_game;
   assign push       = evt_valid && evt_ready;
   // The read stage advances only while the game runs; new_game discards everything in flight.
   assign load       = enable && !new_game;
   assign pop        = load && !raw_empty;
   assign score_evt  = load && rd_valid_reg;
   assign fifo_empty = raw_empty && !rd_valid_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg[PTR_W-1:0]] <= evt_type;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         rd_valid_reg <= 1'b0;
         rd_type_reg  <= EVT_PELLET;
      end else if (new_game) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (load) begin
            rd_valid_reg <= !raw_empty;
         end
         if (pop) begin
            rd_type_reg <= evt_t'(mem[rd_ptr_reg[PTR_W-1:0]]);
            rd_ptr_reg  <= rd_ptr_reg + 1'b1;
         end
      end
   end

   always_comb begin
      pts = '0;
      case (rd_type_reg)
         EVT_PELLET: pts = SUM_W'(PELLET_PTS);
         EVT_POWER:  pts = SUM_W'(POWER_PTS);
         EVT_FRUIT:  pts = SUM_W'(FRUIT_PTS);
         EVT_GHOST:  pts = SUM_W'(GHOST_BASE) << idx_reg;
         default:    pts = '0;
      endcase
      sum        = {{(SUM_W-SCORE_W){1'b0}}, score_reg} + pts;
      score_next = (sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : sum[SCORE_W-1:0];
   end

   // chain_clear outranks the increment of a coincident ghost, which still scores at the old idx.
   always_comb begin
      idx_next = idx_reg;
      if (new_game || chain_clear) begin
         idx_next = '0;
      end else if (score_evt && rd_type_reg == EVT_POWER) begin
         idx_next = '0;
      end else if (score_evt && rd_type_reg == EVT_GHOST && idx_reg < IDX_MAX) begin
         idx_next = idx_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         score_reg <= '0;
         high_reg  <= '0;
         idx_reg   <= '0;
      end else begin
         idx_reg <= idx_next;
         if (new_game) begin
            score_reg <= '0;
         end else if (score_evt) begin
            score_reg <= score_next;
            if (score_next > high_reg) begin
               high_reg <= score_next;
            end
         end
      end
   end

   assign score      = score_reg;
   assign high_score = high_reg;

`ifdef SCORE_EXTRA_LIFE_EN
   localparam logic [SUM_W-1:0] LIFE_VAL = SUM_W'(LIFE_THRESH);

   logic life_flag_reg, extra_life_reg, cross;

   assign cross = !life_flag_reg
                  && ({{(SUM_W-SCORE_W){1'b0}}, score_reg} < LIFE_VAL)
                  && ({{(SUM_W-SCORE_W){1'b0}}, score_next} >= LIFE_VAL);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         life_flag_reg  <= 1'b0;
         extra_life_reg <= 1'b0;
      end else if (new_game) begin
         life_flag_reg  <= 1'b0;
         extra_life_reg <= 1'b0;
      end else begin
         extra_life_reg <= score_evt && cross;
         if (score_evt && cross) begin
            life_flag_reg <= 1'b1;
         end
      end
   end

   assign extra_life = extra_life_reg;
`else
   assign extra_life = 1'b0;
`endif

endmodule

// File: tb/tb_score_engine.sv
// Directed self-checking bench for score_engine: one default-width instance plus an 8-bit instance for saturation.
// Extra-life expectations follow whether SCORE_EXTRA_LIFE_EN is defined for the build.
module tb_score_engine;

`ifdef SCORE_EXTRA_LIFE_EN
   localparam logic LIFE_EN = 1'b1;
`else
   localparam logic LIFE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable, new_game, evt_valid, chain_clear;
   logic [1:0]  evt_type;
   logic        evt_ready, extra_life, fifo_empty;
   logic [23:0] score, high_score;

   logic        s_enable, s_new_game, s_evt_valid, s_chain_clear;
   logic [1:0]  s_evt_type;
   logic        s_evt_ready, s_extra_life, s_fifo_empty;
   logic [7:0]  s_score, s_high_score;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   score_engine dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .new_game(new_game),
      .evt_valid(evt_valid), .evt_type(evt_type), .evt_ready(evt_ready),
      .chain_clear(chain_clear), .score(score), .high_score(high_score),
      .extra_life(extra_life), .fifo_empty(fifo_empty)
   );

   score_engine #(.SCORE_W(8), .LIFE_THRESH(240)) u_small (
      .clk(clk), .reset_n(reset_n), .enable(s_enable), .new_game(s_new_game),
      .evt_valid(s_evt_valid), .evt_type(s_evt_type), .evt_ready(s_evt_ready),
      .chain_clear(s_chain_clear), .score(s_score), .high_score(s_high_score),
      .extra_life(s_extra_life), .fifo_empty(s_fifo_empty)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
      $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Reaches 9990 from zero with idx=0: power, 8 ghosts (9400), 5 fruit, 4 pellets.
   task automatic build_9990();
      logic [1:0] seq [18];
      seq[0] = 2'b01;
      for (int i = 1; i <= 8; i++) seq[i] = 2'b11;
      for (int i = 9; i <= 13; i++) seq[i] = 2'b10;
      for (int i = 14; i <= 17; i++) seq[i] = 2'b00;
      enable = 1'b1;
      for (int i = 0; i < 18; i++) begin
         evt_valid = 1'b1;
         evt_type  = seq[i];
         cyc();
      end
      evt_valid = 1'b0;
      repeat (3) cyc();
   endtask

   initial begin
      logic [23:0] exp_g [8];
      logic [1:0]  typ_g [8];
      logic [23:0] exp_c [7];
      logic [1:0]  typ_c [7];
      logic [7:0]  exp_s [6];
      logic [1:0]  typ_s [4];

      reset_n = 1'b0;
      enable = 1'b0; new_game = 1'b0; evt_valid = 1'b0; chain_clear = 1'b0; evt_type = 2'b00;
      s_enable = 1'b0; s_new_game = 1'b0; s_evt_valid = 1'b0; s_chain_clear = 1'b0; s_evt_type = 2'b00;
      repeat (2) cyc();
      chk("rst_score", score, 0);
      chk("rst_high", high_score, 0);
      chk("rst_life", extra_life, 0);
      chk("rst_empty", fifo_empty, 1);
      chk("rst_ready", evt_ready, 1);
      reset_n = 1'b1;
      cyc();

      // pellet, fruit, power back to back
      enable = 1'b1;
      evt_valid = 1'b1; evt_type = 2'b00; cyc();
      evt_type = 2'b10; cyc();
      chk("t1_n1", score, 0);
      evt_type = 2'b01; cyc();
      chk("t1_n2", score, 10);
      chk("t1_high_n2", high_score, 10);
      evt_valid = 1'b0; cyc();
      chk("t1_n3", score, 110);
      cyc();
      chk("t1_n4", score, 160);
      chk("t1_high_n4", high_score, 160);
      cyc();
      chk("t1_empty", fifo_empty, 1);

      // power then five ghosts: +50,200,400,800,1600,1600
      typ_g = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
      exp_g = '{24'd160, 24'd160, 24'd210, 24'd410, 24'd810, 24'd1610, 24'd3210, 24'd4810};
      for (int i = 0; i < 8; i++) begin
         evt_valid = (i < 6);
         evt_type  = typ_g[i];
         cyc();
         chk($sformatf("ghost_e%0d", i), score, exp_g[i]);
      end

      // chain_clear during the third ghost's scoring cycle: 800 then 200
      typ_c = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
      exp_c = '{24'd4810, 24'd4810, 24'd4860, 24'd5060, 24'd5460, 24'd6260, 24'd6460};
      for (int i = 0; i < 7; i++) begin
         evt_valid   = (i < 5);
         evt_type    = typ_c[i];
         chain_clear = (i == 5);
         cyc();
         chk($sformatf("clr_e%0d", i), score, exp_c[i]);
      end
      chain_clear = 1'b0;

      // enable low: fill FIFO, reject fifth, then drain in order
      enable = 1'b0;
      typ_s = '{2'b00, 2'b10, 2'b00, 2'b10};
      for (int i = 0; i < 4; i++) begin
         evt_valid = 1'b1;
         evt_type  = typ_s[i];
         cyc();
      end
      chk("full_ready", evt_ready, 0);
      chk("full_empty", fifo_empty, 0);
      evt_type = 2'b11; cyc();
      chk("hold_score", score, 6460);
      chk("fifth_ready", evt_ready, 0);
      evt_valid = 1'b0; enable = 1'b1;
      cyc(); chk("drain_d0", score, 6460);
      cyc(); chk("drain_d1", score, 6470);
      cyc(); chk("drain_d2", score, 6570);
      cyc(); chk("drain_d3", score, 6580);
      cyc(); chk("drain_d4", score, 6680);
      chk("drain_empty", fifo_empty, 1);
      cyc(); chk("drain_after", score, 6680);

      // new_game with three queued events
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         evt_valid = 1'b1; evt_type = 2'b00; cyc();
      end
      new_game = 1'b1; evt_type = 2'b10; cyc();
      new_game = 1'b0; evt_valid = 1'b0;
      chk("ng_score", score, 0);
      chk("ng_empty", fifo_empty, 1);
      chk("ng_high", high_score, 6680);
      enable = 1'b1;
      repeat (3) cyc();
      chk("ng_flushed", score, 0);

      // extra life on the 9990 -> 10000 crossing, twice across two games
      for (int g = 0; g < 2; g++) begin
         build_9990();
         chk($sformatf("g%0d_9990", g), score, 9990);
         chk($sformatf("g%0d_life_pre", g), extra_life, 0);
         evt_valid = 1'b1; evt_type = 2'b00; cyc();
         evt_valid = 1'b0; cyc();
         chk($sformatf("g%0d_life_p1", g), extra_life, 0);
         cyc();
         chk($sformatf("g%0d_10000", g), score, 10000);
         chk($sformatf("g%0d_life_p2", g), extra_life, LIFE_EN);
         cyc();
         chk($sformatf("g%0d_life_p3", g), extra_life, 0);
         chk($sformatf("g%0d_high", g), high_score, 10000);
         new_game = 1'b1; cyc(); new_game = 1'b0;
         chk($sformatf("g%0d_ng_score", g), score, 0);
      end
      chk("ng_keep_high", high_score, 10000);

      // async reset clears high score without a clock edge
      @(negedge clk);
      reset_n = 1'b0;
      #2;
      chk("arst_high", high_score, 0);
      chk("arst_score", score, 0);
      cyc();
      reset_n = 1'b1;
      cyc();

      // 8-bit instance: power, ghost -> 250, fruit saturates at 255, pellet holds
      s_enable = 1'b1;
      typ_s = '{2'b01, 2'b11, 2'b10, 2'b00};
      exp_s = '{8'd0, 8'd0, 8'd50, 8'd250, 8'd255, 8'd255};
      for (int i = 0; i < 6; i++) begin
         s_evt_valid = (i < 4);
         s_evt_type  = (i < 4) ? typ_s[i] : 2'b00;
         cyc();
         chk($sformatf("sat_e%0d", i), s_score, exp_s[i]);
         chk($sformatf("sat_life_e%0d", i), s_extra_life, (i == 3) ? LIFE_EN : 1'b0);
      end
      chk("sat_high", s_high_score, 255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/score_engine.md
# score_engine

Parametrised score unit for the Pacman game datapath. It accepts scoring events from the collision/game-logic FSM through a valid/ready handshake and buffers them in a small FIFO. It drains one event per enabled cycle, computing points with a ghost-chain multiplier and saturating arithmetic, and maintains the current score, high score and an extra-life pulse for the HUD and lives counter.

## Interface
- SCORE_W, 24: score / high-score width in bits
- EVT_DEPTH, 4: event FIFO depth; power of two, ≥ 2
- PELLET_PTS, 10: points for pellet event
- POWER_PTS, 50: points for power-pellet event
- FRUIT_PTS, 100: points for fruit event
- GHOST_BASE, 200: points for first ghost of a chain
- GHOST_CHAIN_MAX, 4: chain steps; ghost points = GHOST_BASE << idx, idx ≤ GHOST_CHAIN_MAX-1
- LIFE_THRESH, 10000: score at which one extra life is awarded

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  drain enable (game running, not paused)
- new_game  in  1  synchronous clear for a new game
- evt_valid  in  1  event offered
- evt_type  in  2  00 pellet, 01 power pellet, 10 fruit, 11 ghost
- evt_ready  out  1  event accepted when evt_valid && evt_ready
- chain_clear  in  1  power mode ended; reset ghost chain
- score  out  SCORE_W  current score
- high_score  out  SCORE_W  highest score since reset
- extra_life  out  1  one-cycle award pulse
- fifo_empty  out  1  no pending events

## Operation
- Reset (async, reset_n=0): score=0, high_score=0, extra_life=0, chain idx=0, life-awarded flag=0, FIFO empty (fifo_empty=1, evt_ready=1).
- Push: evt_ready = !full && !new_game. Accepted events are written in order. Push and pop in the same cycle are legal.
- Pop: when enable && !fifo_empty, the head event is removed and its points are added to score.
- Points: pellet=PELLET_PTS; fruit=FRUIT_PTS; power=POWER_PTS and chain idx←0; ghost=GHOST_BASE<<idx, then idx←min(idx+1, GHOST_CHAIN_MAX-1).
- Arithmetic: sum computed at SCORE_W+1 bits. score←(sum overflows) ? 2^SCORE_W-1 : sum. Score saturates and never wraps.
- chain_clear: idx←0. If it coincides with a ghost pop, the ghost uses the current idx and idx ends at 0 (clear wins).
- High score: when the new score > high_score, high_score is written with the new score on the same edge as the score update. new_game does not clear high_score.
- new_game (highest priority, synchronous): score←0, idx←0, life flag←0, FIFO flushed. Any pop or push in that cycle is discarded.
- enable=0: FIFO contents and score hold. Pushes are still accepted until full.

## Timing
- Event accepted at edge N is poppable in cycle N+1; score, high_score and extra_life update at edge N+2 at the earliest.
- Throughput: 1 event/cycle sustained when enable=1.
- extra_life is high for exactly one cycle, coincident with the score update where old < LIFE_THRESH ≤ new and the flag is clear; the flag then sets. At most one award per game.
- Saturation or a score update always appears one edge after the pop cycle. There are no combinational paths from evt_* to score.
- Async reset mid-operation drops all queued events immediately.

## Configuration
- SCORE_EXTRA_LIFE_EN defined: extra-life threshold compare, life-awarded flag and extra_life pulse are built as above.
- Undefined: the comparator and flag are omitted and extra_life is tied 0. All other behaviour is identical.

## Test plan
- Reset, then push pellet, fruit, power on consecutive cycles with enable=1 → score 10, 110, 160 at edges N+2..N+4; high_score tracks.
- Power, then 5 ghosts → ghost points 200, 400, 800, 1600, 1600; final score 4650. Assert chain_clear with the third ghost pop → that ghost scores 800, the next scores 200.
- enable=0, push 4 events → evt_ready low after the 4th, 5th offer not accepted. enable=1 → drains in order over 4 cycles, fifo_empty=1 after.
- SCORE_W=8: score 250 + fruit → score 255 (saturated), no wrap. A further pellet keeps 255.
- Score 9990 + pellet → score 10000 with extra_life high for 1 cycle. Another crossing after a drop is impossible within the game; after new_game, crossing again pulses once more. Build without SCORE_EXTRA_LIFE_EN → extra_life stays 0.
- new_game with 3 queued events and score 500, high_score 500 → next cycle score 0, fifo_empty=1, high_score 500. Reset_n pulse → high_score 0.
